// File: rtl/vga_display_ctrl.sv
// VGA output stage: pixel-enable divider, h/v timing, frame-memory addressing,
// sync/blank alignment to the memory read latency and per-frame colour selection.
module vga_display_ctrl #(
  parameter int COLOUR_W     = 8,
  parameter int CLK_DIV      = 2,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int RD_LAT       = 1,
  parameter logic [COLOUR_W-1:0] WIN_COLOUR = 8'h20,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          MASTER_STATE,
  output logic [9:0]          ADDRH,
  output logic [8:0]          ADDRV,
  input  logic [COLOUR_W-1:0] CIN,
  output logic [COLOUR_W-1:0] COUT,
  output logic                HS,
  output logic                VS,
  output logic                FRAME_START
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_WON, ST_IDLE_ALT} mstate_t;

  logic [DIV_W-1:0] div_reg;
  logic [9:0]       hcnt_reg, vcnt_reg;
  logic             pe, h_last, v_last, wrap;
  logic             vis_raw, hs_raw, vs_raw;
  logic [2:0]       align_pipe [0:RD_LAT];
  mstate_t          state_reg, state_next;
  logic             phase_reg, phase_next;
  logic [BLK_W-1:0] blink_reg, blink_next;
  logic [COLOUR_W-1:0] sel;

  assign pe          = (div_reg == DIV_LAST);
  assign h_last      = (hcnt_reg == H_LAST);
  assign v_last      = (vcnt_reg == V_LAST);
  assign wrap        = pe && h_last && v_last;
  assign FRAME_START = wrap;

  assign vis_raw = (hcnt_reg < H_VIS_L) && (vcnt_reg < V_VIS_L);
  assign hs_raw  = !((hcnt_reg >= HS_BEG) && (hcnt_reg < HS_END));
  assign vs_raw  = !((vcnt_reg >= VS_BEG) && (vcnt_reg < VS_END));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   div_reg <= '0;
    else if (pe) div_reg <= '0;
    else         div_reg <= div_reg + 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hcnt_reg <= '0;
      vcnt_reg <= '0;
      ADDRH    <= '0;
      ADDRV    <= '0;
    end else if (pe) begin
      if (h_last) begin
        hcnt_reg <= '0;
        vcnt_reg <= v_last ? 10'd0 : vcnt_reg + 10'd1;
      end else begin
        hcnt_reg <= hcnt_reg + 10'd1;
      end
      ADDRH <= vis_raw ? hcnt_reg : 10'd0;
      ADDRV <= vis_raw ? vcnt_reg[8:0] : 9'd0;
    end
  end

  // Stage 0 is loaded alongside the address, so the tail lines up with CIN.
  // Each entry is {vis, hs, vs}; reset state is blank with syncs inactive.
  for (genvar gi = 0; gi <= RD_LAT; gi++) begin : g_align
    if (gi == 0) begin : g_head
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)   align_pipe[0] <= 3'b011;
        else if (pe) align_pipe[0] <= {vis_raw, hs_raw, vs_raw};
      end
    end else begin : g_tail
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)   align_pipe[gi] <= 3'b011;
        else if (pe) align_pipe[gi] <= align_pipe[gi-1];
      end
    end
  end

  always_comb begin
    sel = '0;
    case (state_reg)
      ST_PLAY: sel = CIN;
      ST_WON:  sel = phase_reg ? WIN_COLOUR : '0;
      default: sel = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HS   <= 1'b1;
      VS   <= 1'b1;
      COUT <= '0;
    end else if (pe) begin
      HS   <= align_pipe[RD_LAT][1];
      VS   <= align_pipe[RD_LAT][0];
      COUT <= align_pipe[RD_LAT][2] ? sel : '0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      phase_reg <= 1'b1;
      blink_reg <= '0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      blink_reg <= blink_next;
    end
  end

  // State is sampled only at frame wrap so a frame is never drawn half-and-half.
  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    blink_next = blink_reg;
    if (wrap) begin
      state_next = mstate_t'(MASTER_STATE);
      if (MASTER_STATE == 2'd2) begin
        if (state_reg == ST_WON) begin
          if (blink_reg == BLK_LAST) begin
            blink_next = '0;
            phase_next = !phase_reg;
          end else begin
            blink_next = blink_reg + 1'b1;
          end
        end else begin
          phase_next = 1'b1;
          blink_next = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Bench for vga_display_ctrl: two instances with reduced timing (CLK_DIV=2/RD_LAT=1
// and CLK_DIV=1/RD_LAT=3) checked every cycle against a position-based model.
module tb_vga_display_ctrl;

  localparam int HV = 16, HF = 2, HSY = 3, HB = 3, HT = 24;
  localparam int VV = 6,  VF = 1, VSY = 2, VB = 2, VT = 11;
  localparam int FRAME = HT * VT;
  localparam int BF = 2;
  localparam logic [7:0] WIN = 8'h20;
  localparam int T_END = 528 * 13 + 100;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [1:0] MASTER_STATE = 2'd0;

  logic [9:0] addrh_a, addrh_b;
  logic [8:0] addrv_a, addrv_b;
  logic [7:0] cin_a, cin_b, cout_a, cout_b;
  logic       hs_a, vs_a, fs_a, hs_b, vs_b, fs_b;

  int  t = 0;
  int  nvec = 0, nfail = 0;
  bit  running = 0, done_main = 0;
  logic [1:0] st_a [0:63] = '{default: 2'd0};
  logic [1:0] st_b [0:63] = '{default: 2'd0};
  logic [7:0] mem_a = 8'd0;
  logic [7:0] mem_b [0:2] = '{default: 8'd0};

  vga_display_ctrl #(
    .COLOUR_W(8), .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .RD_LAT(1),
    .WIN_COLOUR(WIN), .BLINK_FRAMES(BF)
  ) dut_a (
    .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE),
    .ADDRH(addrh_a), .ADDRV(addrv_a), .CIN(cin_a), .COUT(cout_a),
    .HS(hs_a), .VS(vs_a), .FRAME_START(fs_a)
  );

  vga_display_ctrl #(
    .COLOUR_W(8), .CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .RD_LAT(3),
    .WIN_COLOUR(WIN), .BLINK_FRAMES(BF)
  ) dut_b (
    .CLK(CLK), .RESET(RESET), .MASTER_STATE(MASTER_STATE),
    .ADDRH(addrh_b), .ADDRV(addrv_b), .CIN(cin_b), .COUT(cout_b),
    .HS(hs_b), .VS(vs_b), .FRAME_START(fs_b)
  );

  always #5 CLK = ~CLK;

  // Frame memory content: column mixed with low row bits.
  function automatic logic [7:0] pix(input logic [9:0] h, input logic [8:0] v);
    return h[7:0] ^ {v[3:0], 4'b0000};
  endfunction

  function automatic bit is_wrap(input int cdiv, input int tt);
    return (tt % cdiv == cdiv - 1) && ((tt / cdiv) % FRAME == FRAME - 1);
  endfunction

  // Edge counter, per-frame latched-state record and the two memory models.
  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      t        <= 0;
      mem_a    <= 8'd0;
      mem_b[0] <= 8'd0;
      mem_b[1] <= 8'd0;
      mem_b[2] <= 8'd0;
    end else begin
      t <= t + 1;
      if (is_wrap(2, t)) st_a[(((t / 2) + 1) / FRAME) % 64] <= MASTER_STATE;
      if (is_wrap(1, t)) st_b[((t + 1) / FRAME) % 64] <= MASTER_STATE;
      if (t % 2 == 1) mem_a <= pix(addrh_a, addrv_a);
      mem_b[0] <= pix(addrh_b, addrv_b);
      mem_b[1] <= mem_b[0];
      mem_b[2] <= mem_b[1];
    end
  end

  assign cin_a = mem_a;
  assign cin_b = mem_b[2];

  function automatic logic [1:0] fstate(input int which, input int f);
    if (f <= 0 || f > 63) return 2'd0;
    return (which == 0) ? st_a[f] : st_b[f];
  endfunction

  function automatic bit phase_on(input int which, input int f);
    int r = 0;
    int g = f;
    while (g >= 1 && fstate(which, g) == 2'd2) begin
      r++;
      g--;
    end
    return (((r - 1) / BF) % 2) == 0;
  endfunction

  // Expected outputs after tt edges: addresses show pixel k-1, outputs pixel k-2-rdl.
  task automatic model(input int which, input int cdiv, input int rdl, input int tt,
                       output int eh, output int ev, output int ehs, output int evs,
                       output int ec, output int efs);
    int k, j, hc, vc, fr;
    logic [1:0] s;
    k = tt / cdiv;
    eh = 0; ev = 0; ehs = 1; evs = 1; ec = 0;
    if (k >= 1) begin
      j = (k - 1) % FRAME;
      hc = j % HT;
      vc = j / HT;
      if (hc < HV && vc < VV) begin
        eh = hc;
        ev = vc;
      end
    end
    j = k - 2 - rdl;
    if (j >= 0) begin
      hc = j % HT;
      vc = (j / HT) % VT;
      fr = j / FRAME;
      ehs = (hc >= HV + HF && hc < HV + HF + HSY) ? 0 : 1;
      evs = (vc >= VV + VF && vc < VV + VF + VSY) ? 0 : 1;
      if (hc < HV && vc < VV) begin
        s = fstate(which, fr);
        if (s == 2'd1)      ec = (hc ^ ((vc % 16) * 16)) % 256;
        else if (s == 2'd2) ec = phase_on(which, fr) ? int'(WIN) : 0;
      end
    end
    efs = (tt % cdiv == cdiv - 1 && k % FRAME == FRAME - 1) ? 1 : 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    nvec++;
    if (act !== exp_v) begin
      nfail++;
      $display("FAIL %s t=%0d got %0h expected %0h", nm, t, act, exp_v);
    end
  endtask

  logic phs_a = 1'b1, pvs_a = 1'b1, pfs_a = 1'b0, phs_b = 1'b1, pfs_b = 1'b0;
  int   hs_fall_a = -1, vs_fall_a = -1, fs_last_a = -1, fs_cnt_a = 0;
  int   hs_fall_b = -1, fs_last_b = -1, fs_cnt_b = 0;
  bit   seen_addr1 = 0;

  always @(negedge CLK) begin : compare
    int eh, ev, ehs, evs, ec, efs;
    if (running && RESET) begin
      seen_addr1 = 0;
    end else if (running) begin
      model(0, 2, 1, t, eh, ev, ehs, evs, ec, efs);
      chk("A_addrh", 32'(addrh_a), eh);
      chk("A_addrv", 32'(addrv_a), ev);
      chk("A_hs", 32'(hs_a), ehs);
      chk("A_vs", 32'(vs_a), evs);
      chk("A_cout", 32'(cout_a), ec);
      chk("A_frame_start", 32'(fs_a), efs);
      model(1, 1, 3, t, eh, ev, ehs, evs, ec, efs);
      chk("B_addrh", 32'(addrh_b), eh);
      chk("B_addrv", 32'(addrv_b), ev);
      chk("B_hs", 32'(hs_b), ehs);
      chk("B_vs", 32'(vs_b), evs);
      chk("B_cout", 32'(cout_b), ec);
      chk("B_frame_start", 32'(fs_b), efs);

      if (!seen_addr1 && addrh_a == 10'd1) begin
        seen_addr1 = 1;
        chk("A_addrh1_time", t, 4);
      end

      if (!done_main) begin
        // Hand-computed pixels: frame 0 after mid-frame switch, playing, blink, blanking.
        if (t == 246)  chk("A_f0_mid_switch_black", 32'(cout_a), 32'h00);
        if (t == 640)  chk("A_f1_px5_2", 32'(cout_a), 32'h25);
        if (t == 1062) chk("A_f2_win_on", 32'(cout_a), 32'h20);
        if (t == 1094) chk("A_f2_blank_forced", 32'(cout_a), 32'h00);
        if (t == 2118) chk("A_f4_win_off", 32'(cout_a), 32'h00);
        if (t == 3174) chk("A_f6_win_on", 32'(cout_a), 32'h20);
        if (t == 4230) chk("A_f8_idle", 32'(cout_a), 32'h00);
        if (t == 4758) chk("A_f9_reenter_on", 32'(cout_a), 32'h20);
        if (t == 5814) chk("A_f11_off", 32'(cout_a), 32'h00);
        if (t == 6342) chk("A_f12_state3", 32'(cout_a), 32'h00);

        if (phs_a && !hs_a) begin
          if (hs_fall_a >= 0) chk("A_hs_period", t - hs_fall_a, 48);
          else                chk("A_first_hs_fall", t, 42);
          hs_fall_a = t;
        end
        if (!phs_a && hs_a) chk("A_hs_width", t - hs_fall_a, 6);
        if (pvs_a && !vs_a) vs_fall_a = t;
        if (!pvs_a && vs_a) chk("A_vs_width", t - vs_fall_a, 96);
        if (!pfs_a && fs_a) begin
          if (fs_last_a >= 0) chk("A_fs_period", t - fs_last_a, 528);
          fs_last_a = t;
          fs_cnt_a++;
        end
        if (phs_b && !hs_b) begin
          if (hs_fall_b >= 0) chk("B_hs_period", t - hs_fall_b, 24);
          else                chk("B_first_hs_fall", t, 23);
          hs_fall_b = t;
        end
        if (!pfs_b && fs_b) begin
          if (fs_last_b >= 0) chk("B_fs_period", t - fs_last_b, 264);
          fs_last_b = t;
          fs_cnt_b++;
        end
        phs_a = hs_a; pvs_a = vs_a; pfs_a = fs_a; phs_b = hs_b; pfs_b = fs_b;

        if (t == T_END) begin
          chk("A_fs_count", fs_cnt_a, 13);
          chk("B_fs_count", fs_cnt_b, 26);
          done_main = 1;
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #2 RESET = 1'b0;
    running = 1;
    for (int cyc = 0; cyc < T_END + 10 && !done_main; cyc++) begin
      @(negedge CLK);
      #1;
      case (t)
        200:           MASTER_STATE = 2'd1;
        528 * 1 + 300: MASTER_STATE = 2'd2;
        528 * 7 + 300: MASTER_STATE = 2'd0;
        528 * 8 + 300: MASTER_STATE = 2'd2;
        528 * 11 + 300: MASTER_STATE = 2'd3;
        default: ;
      endcase
    end
    if (!done_main) chk("main_run_completed", 32'd0, 32'd1);

    // Asynchronous reset asserted mid-line between clock edges.
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("rst_A_hs", 32'(hs_a), 1);
    chk("rst_A_vs", 32'(vs_a), 1);
    chk("rst_A_cout", 32'(cout_a), 0);
    chk("rst_A_addrh", 32'(addrh_a), 0);
    chk("rst_A_addrv", 32'(addrv_a), 0);
    chk("rst_A_fs", 32'(fs_a), 0);
    chk("rst_B_hs", 32'(hs_b), 1);
    chk("rst_B_vs", 32'(vs_b), 1);
    chk("rst_B_cout", 32'(cout_b), 0);
    chk("rst_B_addrh", 32'(addrh_b), 0);
    MASTER_STATE = 2'd1;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    repeat (60) @(negedge CLK);
    #1;
    if (!seen_addr1) chk("A_addrh1_after_reset_seen", 32'd0, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
